pair_unbundle_serializer: RTL and testbench



---
 rtl/pair_unbundle_serializer.sv | 103 ++++++++++
 tb/tb_pair_unbundle_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_unbundle_serializer.sv
// Serializes a two-field signed pair onto one WIDTH-bit valid/ready stream,
// marking the second word with last and counting completed pairs.
module pair_unbundle_serializer #(
  parameter int WIDTH     = 9,
  parameter int FIRST_SEL = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   system1000,
  input  logic                   system1000_rst,
  input  logic [2*WIDTH-1:0]     pair_i,
  input  logic                   pair_valid_i,
  output logic                   pair_ready_o,
  output logic [WIDTH-1:0]       word_o,
  output logic                   word_valid_o,
  output logic                   word_last_o,
  input  logic                   word_ready_i,
  output logic [CNT_WIDTH-1:0]   pair_count_o
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t                 r_state;
  logic [2*WIDTH-1:0]     r_hold;
  logic [WIDTH-1:0]       r_word;
  logic                   r_valid;
  logic                   r_last;
  logic [CNT_WIDTH-1:0]   r_count;

  logic                   w_accept;
  logic [WIDTH-1:0]       w_in_first;
  logic [WIDTH-1:0]       w_hold_second;

  assign w_in_first    = (FIRST_SEL == 0) ? pair_i[2*WIDTH-1:WIDTH] : pair_i[WIDTH-1:0];
  assign w_hold_second = (FIRST_SEL == 0) ? r_hold[WIDTH-1:0] : r_hold[2*WIDTH-1:WIDTH];

  // Ready in SECOND follows the downstream so a new pair loads on the edge
  // that retires the current last word, giving a bubble-free 2-cycle rate.
  always_comb begin
    pair_ready_o = 1'b0;
    if (!system1000_rst) begin
      case (r_state)
        IDLE:    pair_ready_o = 1'b1;
        SECOND:  pair_ready_o = word_ready_i;
        default: pair_ready_o = 1'b0;
      endcase
    end
  end

  assign w_accept = pair_valid_i && pair_ready_o;

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hold  <= pair_i;
            r_word  <= w_in_first;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= FIRST;
          end
        end
        FIRST: begin
          if (word_ready_i) begin
            r_word  <= w_hold_second;
            r_last  <= 1'b1;
            r_state <= SECOND;
          end
        end
        SECOND: begin
          if (word_ready_i) begin
            r_count <= r_count + CNT_WIDTH'(1);
            if (w_accept) begin
              r_hold  <= pair_i;
              r_word  <= w_in_first;
              r_valid <= 1'b1;
              r_last  <= 1'b0;
              r_state <= FIRST;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign word_o       = r_word;
  assign word_valid_o = r_valid;
  assign word_last_o  = r_last;
  assign pair_count_o = r_count;

endmodule

// File: tb/tb_pair_unbundle_serializer.sv
// Bench for pair_unbundle_serializer: three configurations share one stimulus
// stream and are checked against a word-queue reference model.
module tb_pair_unbundle_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] pair_i = '0;
  logic        pair_valid_i = 1'b0;
  logic        word_ready_i = 1'b0;

  logic        rdy0, rdy1, rdy2;
  logic [8:0]  word0, word1, word2;
  logic        val0, val1, val2;
  logic        last0, last1, last2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  pair_unbundle_serializer #(.WIDTH(9), .FIRST_SEL(0), .CNT_WIDTH(16)) dut0 (
    .system1000(clk), .system1000_rst(rst), .pair_i(pair_i), .pair_valid_i(pair_valid_i),
    .pair_ready_o(rdy0), .word_o(word0), .word_valid_o(val0), .word_last_o(last0),
    .word_ready_i(word_ready_i), .pair_count_o(cnt0));

  pair_unbundle_serializer #(.WIDTH(9), .FIRST_SEL(1), .CNT_WIDTH(16)) dut1 (
    .system1000(clk), .system1000_rst(rst), .pair_i(pair_i), .pair_valid_i(pair_valid_i),
    .pair_ready_o(rdy1), .word_o(word1), .word_valid_o(val1), .word_last_o(last1),
    .word_ready_i(word_ready_i), .pair_count_o(cnt1));

  pair_unbundle_serializer #(.WIDTH(9), .FIRST_SEL(0), .CNT_WIDTH(2)) dut2 (
    .system1000(clk), .system1000_rst(rst), .pair_i(pair_i), .pair_valid_i(pair_valid_i),
    .pair_ready_o(rdy2), .word_o(word2), .word_valid_o(val2), .word_last_o(last2),
    .word_ready_i(word_ready_i), .pair_count_o(cnt2));

  int checks = 0;
  int failures = 0;

  // Reference model: words still owed downstream, in emission order.
  typedef struct {
    logic [8:0] w0;
    logic [8:0] w1;
    logic       last;
  } mw_t;
  mw_t         q[$];
  int unsigned m_count = 0;
  logic [8:0]  m_lastw0 = '0;
  logic [8:0]  m_lastw1 = '0;

  typedef struct {
    logic        pv;
    logic [17:0] pd;
    logic        wr;
    logic        e_valid;
    logic        e_last;
    logic        e_ready;
    logic [8:0]  e_word;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic pv, input logic [17:0] pd, input logic wr, output bit acc);
    int   pending;
    logic e_ready, e_valid;
    @(negedge clk);
    pair_valid_i = pv;
    pair_i       = pd;
    word_ready_i = wr;
    #1;
    pending = q.size();
    e_valid = (pending > 0);
    e_ready = (pending == 0) ? 1'b1 : ((pending == 1) ? wr : 1'b0);
    chk("m_ready0", rdy0, e_ready);
    chk("m_ready1", rdy1, e_ready);
    chk("m_ready2", rdy2, e_ready);
    chk("m_valid0", val0, e_valid);
    chk("m_valid1", val1, e_valid);
    chk("m_valid2", val2, e_valid);
    if (e_valid) begin
      chk("m_word0", word0, q[0].w0);
      chk("m_word1", word1, q[0].w1);
      chk("m_word2", word2, q[0].w0);
      chk("m_last0", last0, q[0].last);
      chk("m_last1", last1, q[0].last);
      chk("m_last2", last2, q[0].last);
    end else begin
      chk("m_idle_word0", word0, m_lastw0);
      chk("m_idle_word1", word1, m_lastw1);
      chk("m_idle_last0", last0, 1'b0);
      chk("m_idle_last1", last1, 1'b0);
    end
    chk("m_cnt0", cnt0, m_count[15:0]);
    chk("m_cnt1", cnt1, m_count[15:0]);
    chk("m_cnt2", cnt2, m_count[1:0]);
    if (e_valid && wr) begin
      mw_t h;
      h = q.pop_front();
      m_lastw0 = h.w0;
      m_lastw1 = h.w1;
      if (h.last) m_count++;
    end
    acc = e_ready && pv;
    if (acc) begin
      q.push_back('{pd[17:9], pd[8:0], 1'b0});
      q.push_back('{pd[8:0], pd[17:9], 1'b1});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    pair_valid_i = 1'b0;
    word_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_word0", word0, 9'h0);
    chk("rst_word1", word1, 9'h0);
    chk("rst_valid0", val0, 1'b0);
    chk("rst_last0", last0, 1'b0);
    chk("rst_cnt0", cnt0, 16'h0);
    chk("rst_cnt2", cnt2, 2'h0);
    chk("rst_ready0", rdy0, 1'b0);
    q.delete();
    m_count  = 0;
    m_lastw0 = '0;
    m_lastw1 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [17:0] P;
    logic [17:0] bb[4];
    logic [8:0]  bseq[8];
    logic [17:0] wp[5];
    logic [1:0]  wseq[5];
    logic        cur_pv;
    logic [17:0] cur_pd;

    P = {9'h1FD, 9'd100};
    tbl[0]  = '{1'b1, P,     1'b1, 1'b0, 1'b0, 1'b1, 9'h000, 16'd0};
    tbl[1]  = '{1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1FD, 16'd0};
    tbl[2]  = '{1'b0, 18'h0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd100, 16'd0};
    tbl[3]  = '{1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd100, 16'd1};
    tbl[4]  = '{1'b1, P,     1'b0, 1'b0, 1'b0, 1'b1, 9'd100, 16'd1};
    tbl[5]  = '{1'b0, 18'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FD, 16'd1};
    tbl[6]  = '{1'b0, 18'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FD, 16'd1};
    tbl[7]  = '{1'b0, 18'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FD, 16'd1};
    tbl[8]  = '{1'b0, 18'h0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h1FD, 16'd1};
    tbl[9]  = '{1'b0, 18'h0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd100, 16'd1};
    tbl[10] = '{1'b0, 18'h0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd100, 16'd1};
    tbl[11] = '{1'b0, 18'h0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd100, 16'd1};
    tbl[12] = '{1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd100, 16'd2};

    do_reset();

    // Basic transfer and backpressure, table driven.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].pv, tbl[i].pd, tbl[i].wr, acc);
      chk($sformatf("tbl%0d_valid", i), val0, tbl[i].e_valid);
      chk($sformatf("tbl%0d_last", i), last0, tbl[i].e_last);
      chk($sformatf("tbl%0d_ready", i), rdy0, tbl[i].e_ready);
      chk($sformatf("tbl%0d_word", i), word0, tbl[i].e_word);
      chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].e_cnt);
    end

    // Back-to-back stream of four pairs.
    do_reset();
    bb[0] = {9'd1, 9'd2};
    bb[1] = {9'd3, 9'd4};
    bb[2] = {9'h1FF, 9'h1FE};
    bb[3] = {9'h0FF, 9'h100};
    bseq = '{9'd1, 9'd2, 9'd3, 9'd4, 9'h1FF, 9'h1FE, 9'h0FF, 9'h100};
    step(1'b1, bb[0], 1'b1, acc);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 18'h0, 1'b1, acc);
      chk("b2b_first_word", word0, bseq[2*k]);
      chk("b2b_first_last", last0, 1'b0);
      step(k < 3, bb[(k+1)%4], 1'b1, acc);
      chk("b2b_second_word", word0, bseq[2*k+1]);
      chk("b2b_second_last", last0, 1'b1);
    end
    step(1'b0, 18'h0, 1'b1, acc);
    chk("b2b_end_valid", val0, 1'b0);
    chk("b2b_count", cnt0, 16'd4);

    // Reversed field order.
    step(1'b1, {9'd7, 9'h1F8}, 1'b1, acc);
    step(1'b0, 18'h0, 1'b0, acc);
    chk("sel1_first_word", word1, 9'h1F8);
    chk("sel1_first_last", last1, 1'b0);
    step(1'b0, 18'h0, 1'b1, acc);
    step(1'b0, 18'h0, 1'b1, acc);
    chk("sel1_second_word", word1, 9'd7);
    chk("sel1_second_last", last1, 1'b1);
    step(1'b0, 18'h0, 1'b1, acc);

    // Reset while the second word is stalled.
    step(1'b1, {9'd9, 9'd10}, 1'b1, acc);
    step(1'b0, 18'h0, 1'b1, acc);
    step(1'b0, 18'h0, 1'b0, acc);
    do_reset();
    step(1'b1, {9'd5, 9'd6}, 1'b1, acc);
    step(1'b0, 18'h0, 1'b1, acc);
    chk("postrst_word_a", word0, 9'd5);
    chk("postrst_last_a", last0, 1'b0);
    step(1'b0, 18'h0, 1'b1, acc);
    chk("postrst_word_b", word0, 9'd6);
    chk("postrst_last_b", last0, 1'b1);
    step(1'b0, 18'h0, 1'b1, acc);
    chk("postrst_idle", val0, 1'b0);
    chk("postrst_cnt", cnt0, 16'd1);

    // Narrow counter wrap.
    do_reset();
    wp = '{{9'd11, 9'd12}, {9'd13, 9'd14}, {9'd15, 9'd16}, {9'd17, 9'd18}, {9'd19, 9'd20}};
    wseq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, wp[k], 1'b1, acc);
      step(1'b0, 18'h0, 1'b1, acc);
      if (k >= 1) chk("wrap_cnt", cnt2, wseq[k-1]);
    end
    step(1'b0, 18'h0, 1'b1, acc);
    step(1'b0, 18'h0, 1'b1, acc);
    chk("wrap_cnt_final", cnt2, wseq[4]);

    // Randomized traffic; a pending pair is held until accepted.
    cur_pv = 1'b0;
    cur_pd = '0;
    acc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        cur_pv = 1'b0;
      end
      if (!cur_pv || acc) begin
        cur_pv = ($urandom_range(0, 9) < 6);
        cur_pd = 18'($urandom);
      end
      step(cur_pv, cur_pd, ($urandom_range(0, 9) < 7), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
